// File: rtl/tristate_bus_arbiter.sv
// Round-robin sequencer for a shared tri-state bus driven by NREQ enable-controlled registers.
// Each change of bus owner passes through DEAD cycles in which every output enable is high.
module tristate_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAXHOLD = 16,
    parameter int DEAD    = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] OENB_N,
    output logic [NREQ-1:0] GNT,
    output logic [2:0]      OWNER,
    output logic            BUS_VALID
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_RST  = 3'(NREQ - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(MAXHOLD);
    localparam logic [7:0] HOLD_LIM  = 8'(MAXHOLD - 1);
    localparam logic [1:0] DEAD_INIT = 2'(DEAD - 1);

    // First set request found scanning upward from last+1, wrapping at NREQ.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, last} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'd1 << idx;
        return v[NREQ-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      last_q, last_d;
    logic [2:0]      owner_q, owner_d;
    logic [7:0]      hcnt_q, hcnt_d;
    logic [1:0]      dcnt_q, dcnt_d;
    logic [NREQ-1:0] oenb_q, oenb_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q, valid_d;

    logic [7:0] req_w_s;
    logic       any_req_s;
    logic       owner_req_s;
    logic       others_req_s;
    logic [2:0] pick_s;

    assign req_w_s      = 8'(REQ);
    assign any_req_s    = |REQ;
    assign owner_req_s  = req_w_s[owner_q];
    assign others_req_s = |(REQ & ~to_onehot(owner_q));
    assign pick_s       = rr_pick(req_w_s, last_q);

    // State and registered-output flops; reset releases the bus on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RST;
            owner_q <= 3'd0;
            hcnt_q  <= 8'd0;
            dcnt_q  <= 2'd0;
            oenb_q  <= {NREQ{1'b1}};
            gnt_q   <= {NREQ{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            hcnt_q  <= hcnt_d;
            dcnt_q  <= dcnt_d;
            oenb_q  <= oenb_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, arbitration, hold and turnaround counters.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        hcnt_d  = hcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = ST_DRIVE;
                    last_d  = pick_s;
                    owner_d = pick_s;
                    hcnt_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // A dropped request and an expired hold on the same edge are one exit.
                if (!owner_req_s || ((hcnt_q >= HOLD_LIM) && others_req_s)) begin
                    state_d = ST_TURN;
                    dcnt_d  = DEAD_INIT;
                end else if (hcnt_q < HOLD_MAX) begin
                    hcnt_d = hcnt_q + 8'd1;
                end else begin
                    hcnt_d = hcnt_q;
                end
            end
            ST_TURN: begin
                if (dcnt_q != 2'd0) begin
                    dcnt_d = dcnt_q - 2'd1;
                end else if (any_req_s) begin
                    state_d = ST_DRIVE;
                    last_d  = pick_s;
                    owner_d = pick_s;
                    hcnt_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        oenb_d  = {NREQ{1'b1}};
        valid_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            oenb_d = ~to_onehot(owner_d);
        end else begin
            oenb_d = {NREQ{1'b1}};
        end
        if ((state_q == ST_DRIVE) && (state_d == ST_DRIVE)) begin
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
        gnt_d = ~oenb_d;
    end

    assign OENB_N    = oenb_q;
    assign GNT       = gnt_q;
    assign OWNER     = owner_q;
    assign BUS_VALID = valid_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: three instances cover MAXHOLD=16/DEAD=1,
// MAXHOLD=4 round-robin, and DEAD=3 turnaround; bus invariants are checked every cycle.
module tb_tristate_bus_arbiter;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] oenb_a, oenb_b, oenb_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [2:0] own_a, own_b, own_c;
    logic       val_a, val_b, val_c;

    int total = 0;
    int bad   = 0;
    logic armed = 1'b0;

    tristate_bus_arbiter #(.NREQ(4), .MAXHOLD(16), .DEAD(1)) dut_a (
        .CLK(clk), .RESET_N(rst_a), .REQ(req_a), .OENB_N(oenb_a),
        .GNT(gnt_a), .OWNER(own_a), .BUS_VALID(val_a));
    tristate_bus_arbiter #(.NREQ(4), .MAXHOLD(4), .DEAD(1)) dut_b (
        .CLK(clk), .RESET_N(rst_b), .REQ(req_b), .OENB_N(oenb_b),
        .GNT(gnt_b), .OWNER(own_b), .BUS_VALID(val_b));
    tristate_bus_arbiter #(.NREQ(4), .MAXHOLD(16), .DEAD(3)) dut_c (
        .CLK(clk), .RESET_N(rst_c), .REQ(req_c), .OENB_N(oenb_c),
        .GNT(gnt_c), .OWNER(own_c), .BUS_VALID(val_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus invariants sampled on the falling edge for every instance.
    logic [3:0] oenb_v [3];
    logic [3:0] gnt_v  [3];
    logic       val_v  [3];
    int         dead_v [3];
    logic [3:0] prev_v [3];
    int         gap_v  [3];
    assign oenb_v[0] = oenb_a; assign oenb_v[1] = oenb_b; assign oenb_v[2] = oenb_c;
    assign gnt_v[0]  = gnt_a;  assign gnt_v[1]  = gnt_b;  assign gnt_v[2]  = gnt_c;
    assign val_v[0]  = val_a;  assign val_v[1]  = val_b;  assign val_v[2]  = val_c;
    initial begin
        dead_v[0] = 1; dead_v[1] = 1; dead_v[2] = 3;
        for (int k = 0; k < 3; k++) begin
            prev_v[k] = 4'b0000;
            gap_v[k]  = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                total = total + 1;
                if (($countones(~oenb_v[k]) > 1) || (gnt_v[k] !== ~oenb_v[k]) ||
                    (val_v[k] && (gnt_v[k] == 4'b0000))) begin
                    bad = bad + 1;
                    $display("FAIL invariant dut%0d: oenb_n=%b gnt=%b valid=%b", k, oenb_v[k], gnt_v[k], val_v[k]);
                end
                if (gnt_v[k] == 4'b0000) begin
                    gap_v[k] = gap_v[k] + 1;
                end else begin
                    if ((prev_v[k] != 4'b0000) && (gnt_v[k] != prev_v[k]) && (gap_v[k] < dead_v[k])) begin
                        bad = bad + 1;
                        $display("FAIL dead_gap dut%0d: gap=%0d required>=%0d", k, gap_v[k], dead_v[k]);
                    end
                    if (gap_v[k] > 0 && gnt_v[k] == prev_v[k]) begin
                        gap_v[k] = 0;
                    end
                    prev_v[k] = gnt_v[k];
                    gap_v[k]  = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = 4'b1111; req_b = 4'b0000; req_c = 4'b0000;
        tick(); tick(); tick();
        armed = 1'b1;
        total = total + 1;
        if (oenb_a !== 4'b1111 || gnt_a !== 4'b0000 || val_a !== 1'b0 || own_a !== 3'd0) begin
            bad = bad + 1;
            $display("FAIL reset_state: oenb_n=%b gnt=%b valid=%b owner=%0d required 1111/0000/0/0", oenb_a, gnt_a, val_a, own_a);
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        total = total + 1;
        if (gnt_a !== 4'b0001 || own_a !== 3'd0 || val_a !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_first_grant: gnt=%b owner=%0d valid=%b required 0001/0/0", gnt_a, own_a, val_a);
        end
        req_a = 4'b0000;
        tick(); tick();
        total = total + 1;
        if (oenb_a !== 4'b1111) begin
            bad = bad + 1;
            $display("FAIL reset_release: oenb_n=%b required 1111", oenb_a);
        end
    endtask

    task automatic test_single();
        req_a = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total = total + 1;
            if (oenb_a !== 4'b1011 || val_a !== (i >= 2) || own_a !== 3'd2) begin
                bad = bad + 1;
                $display("FAIL single_drive c%0d: oenb_n=%b valid=%b owner=%0d required 1011/%0d/2", i, oenb_a, val_a, own_a, (i >= 2));
            end
        end
        req_a = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total = total + 1;
            if (oenb_a !== 4'b1111 || val_a !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL single_release c%0d: oenb_n=%b valid=%b required 1111/0", i, oenb_a, val_a);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [5];
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;
        rst_b = 1'b0;
        req_b = 4'b1111;
        tick();
        rst_b = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                total = total + 1;
                if (gnt_b !== (4'b0001 << seq[s]) || own_b !== 3'(seq[s]) || val_b !== (c >= 1)) begin
                    bad = bad + 1;
                    $display("FAIL rr_hold s%0d c%0d: gnt=%b owner=%0d valid=%b required owner %0d", s, c, gnt_b, own_b, val_b, seq[s]);
                end
            end
            if (s < 4) begin
                tick();
                total = total + 1;
                if (oenb_b !== 4'b1111) begin
                    bad = bad + 1;
                    $display("FAIL rr_dead s%0d: oenb_n=%b required 1111", s, oenb_b);
                end
            end
        end
        req_b = 4'b0000;
    endtask

    task automatic test_preempt();
        int wrong;
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        req_a = 4'b0001;
        wrong = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt_a !== 4'b0001) wrong = wrong + 1;
        end
        total = total + 1;
        if (wrong != 0) begin
            bad = bad + 1;
            $display("FAIL preempt_uncontended: %0d cycles without gnt 0001, required 0", wrong);
        end
        req_a = 4'b0101;
        tick();
        total = total + 1;
        if (oenb_a !== 4'b1111 || val_a !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL preempt_release: oenb_n=%b valid=%b required 1111/0", oenb_a, val_a);
        end
        tick();
        total = total + 1;
        if (gnt_a !== 4'b0100 || own_a !== 3'd2) begin
            bad = bad + 1;
            $display("FAIL preempt_regrant: gnt=%b owner=%0d required 0100/2", gnt_a, own_a);
        end
    endtask

    task automatic test_reset_mid_drive();
        req_a = 4'b0010;
        tick(); tick();
        total = total + 1;
        if (gnt_a !== 4'b0010 || own_a !== 3'd1) begin
            bad = bad + 1;
            $display("FAIL mid_setup: gnt=%b owner=%0d required 0010/1", gnt_a, own_a);
        end
        tick();
        rst_a = 1'b0;
        tick();
        total = total + 1;
        if (oenb_a !== 4'b1111 || val_a !== 1'b0 || own_a !== 3'd0) begin
            bad = bad + 1;
            $display("FAIL mid_reset: oenb_n=%b valid=%b owner=%0d required 1111/0/0", oenb_a, val_a, own_a);
        end
        rst_a = 1'b1;
        tick();
        total = total + 1;
        if (gnt_a !== 4'b0010 || own_a !== 3'd1) begin
            bad = bad + 1;
            $display("FAIL mid_regrant: gnt=%b owner=%0d required 0010/1", gnt_a, own_a);
        end
    endtask

    task automatic test_back_to_back();
        req_a = 4'b0000;
        tick();
        req_a = 4'b0010;
        tick();
        total = total + 1;
        if (gnt_a !== 4'b0010 || val_a !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL sole_regrant: gnt=%b valid=%b required 0010/0", gnt_a, val_a);
        end
        req_a = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_dead3();
        rst_c = 1'b0;
        req_c = 4'b0011;
        tick();
        rst_c = 1'b1;
        tick();
        total = total + 1;
        if (gnt_c !== 4'b0001) begin
            bad = bad + 1;
            $display("FAIL dead3_first: gnt=%b required 0001", gnt_c);
        end
        tick();
        req_c = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total = total + 1;
            if (oenb_c !== 4'b1111) begin
                bad = bad + 1;
                $display("FAIL dead3_gap c%0d: oenb_n=%b required 1111", i, oenb_c);
            end
        end
        tick();
        total = total + 1;
        if (gnt_c !== 4'b0010 || own_c !== 3'd1) begin
            bad = bad + 1;
            $display("FAIL dead3_grant: gnt=%b owner=%0d required 0010/1", gnt_c, own_c);
        end
        req_c = 4'b0000;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_reset_mid_drive();
        test_back_to_back();
        test_dead3();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 8-bit tri-state bus.
- The bus is driven by up to NREQ octal edge-triggered registers with active-low output enables (74S374-style parts).
- Grants one requester at a time and drives that requester's OENB_N low.
- Guarantees at least one break-before-make dead cycle, with every enable high, between owners, so two sources never contend on the bus.

Parameters:
- NREQ, 4: number of requesters / bus-source registers; legal range 2..8.
- MAXHOLD, 16: maximum consecutive DRIVE cycles for one owner while another requester is waiting; legal range 1..255.
- DEAD, 1: number of turnaround cycles with all enables high between owners; legal range 1..3.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  synchronous active-low reset, sampled on the CLK rising edge.
- REQ  input  NREQ  per-source bus request, level-sensitive.
- OENB_N  output  NREQ  per-source active-low output enable to the register parts; at most one bit low.
- GNT  output  NREQ  one-hot grant; equals ~OENB_N.
- OWNER  output  3  index of the current or last owner.
- BUS_VALID  output  1  bus data is stable; high from the second DRIVE cycle onward.

Behaviour:
- All outputs are registered. Internal pointer LAST (3 bits), hold counter HCNT (8 bits), dead counter DCNT (2 bits).
- Reset: RESET_N low at a CLK edge forces, regardless of state:
  - state=IDLE, OENB_N=all 1, GNT=0, BUS_VALID=0, OWNER=0;
  - LAST=NREQ-1 (REQ[0] wins first), HCNT=0, DCNT=0.
  - Reset mid-DRIVE releases the bus on that same edge.
- Arbitration: search REQ starting at index (LAST+1) mod NREQ and increasing with wrap. The first set bit wins. On the grant edge, LAST and OWNER take the winner's index.
- IDLE:
  - If any REQ bit is high, go to DRIVE on the next edge: GNT[w]=1, OENB_N[w]=0, HCNT=0, BUS_VALID=0.
  - Latency: REQ high before edge n gives OENB_N low after edge n.
  - If no REQ bit is high, stay in IDLE.
- DRIVE:
  - BUS_VALID=1 from the second DRIVE cycle onward.
  - HCNT increments each cycle and saturates at MAXHOLD.
  - Exit to TURN when REQ[OWNER]=0, or when HCNT>=MAXHOLD-1 and some other REQ bit is high.
  - On exit: OENB_N=all 1, GNT=0, BUS_VALID=0, DCNT=DEAD-1.
  - If MAXHOLD is reached with no other requester, the owner keeps the bus indefinitely.
- TURN:
  - All enables stay high.
  - While DCNT>0, decrement DCNT.
  - When DCNT=0, apply the IDLE arbitration on the same edge: grant directly if any REQ is high, else go to IDLE.
  - The previous owner may be re-granted only when it is the sole requester.
  - Total all-high time is exactly DEAD cycles.
- Simultaneous events:
  - The owner dropping REQ while MAXHOLD expires is treated as a single exit; no extra dead cycle.
  - REQ bits rising during TURN are considered at TURN end.
- Invariants (assert in bench):
  - popcount(~OENB_N)<=1.
  - GNT==~OENB_N.
  - Every owner change is separated by at least DEAD all-high cycles.
  - BUS_VALID implies a grant is active.

Test Plan:
- Reset: hold RESET_N=0 for 3 cycles with REQ=4'b1111 → OENB_N=4'b1111, GNT=0, BUS_VALID=0. First edge after release → GNT=4'b0001, OWNER=0.
- Single requester: REQ=4'b0100 held 5 cycles, then dropped (DEAD=1) →
  - OENB_N=4'b1011 for 5 cycles;
  - BUS_VALID high on cycles 2-5;
  - then 1 cycle all-high, then IDLE.
- Round-robin: REQ=4'b1111 held, MAXHOLD=4 → owners cycle 0,1,2,3,0. Each owner holds 4 cycles, followed by exactly 1 dead cycle.
- Pre-emption only when contended: REQ=4'b0001 held 40 cycles, MAXHOLD=16 → owner 0 is never released. Then REQ[2] asserts at cycle 40 → release and dead cycle, then GNT=4'b0100.
- Reset mid-DRIVE: owner 1 driving, RESET_N=0 for 1 cycle → OENB_N=4'b1111 on that edge. After release with REQ=4'b0010 → GNT=4'b0010 (LAST reset to NREQ-1).
- Turnaround with DEAD=3: REQ=4'b0011, owner 0 drops REQ → exactly 3 all-high cycles, then GNT=4'b0010. Contention invariant holds throughout.
